dds_cmd_ctrl: RTL and testbench
===============================

Name: dds_cmd_ctrl

Overview:
- Packet-level command controller between the UART byte receiver and the 4-channel DDS core.
- Parses framed, checksummed serial commands into per-channel phase offsets and frequency tuning words.
- Holds new values in shadow registers; a commit command loads all four channels into the active registers in one cycle, so the channels never go out of phase while being reconfigured.
- Replaces ad-hoc byte-to-phase mapping with validated, atomic configuration.

Parameters:
- HDR, 8'hAA, frame header byte.
- PH_W, 10, phase offset width (matches DDS phase input).
- FTW_W, 16, frequency tuning word width.
- DEF_FTW, 16'd1024, reset/default tuning word for all channels.
- TIMEOUT_CYC, 500000, idle cycles between bytes before the partial frame is dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_data  in  8  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle strobe per received byte
- phase_1..phase_4  out  PH_W each  active phase offsets to DDS
- ftw_1..ftw_4  out  FTW_W each  active tuning words to DDS
- update  out  1  one-cycle pulse when active registers change
- cmd_err  out  1  one-cycle pulse on checksum failure or timeout drop
- busy  out  1  high while a frame is partially received

Behaviour:
- Single clock domain: clk. Reset: asynchronous, active-high (rst).
- Reset values:
  - FSM to IDLE.
  - Shadow and active phases = 0; shadow and active ftw = DEF_FTW.
  - update=0, cmd_err=0, busy=0, timeout counter=0.
- Frame format: HDR, CMD, DHI, DLO, CS, where CS = CMD ^ DHI ^ DLO.
- CMD[7:6] opcode, CMD[1:0] channel index (0..3 maps to channel 1..4), CMD[5:2] ignored:
  - 00: write shadow phase[ch] = {DHI,DLO}[PH_W-1:0] (upper bits truncated).
  - 01: write shadow ftw[ch] = {DHI,DLO}[FTW_W-1:0].
  - 10: commit; all active <= shadow; channel, DHI and DLO ignored.
  - 11: defaults; shadow and active <= reset values.
- FSM states IDLE, CMD, DHI, DLO, CS; transitions only on rx_done:
  - IDLE -> CMD only if rx_data==HDR; any other byte is discarded silently.
  - CMD -> DHI -> DLO -> CS, each on the next rx_done.
  - CS -> IDLE always.
  - HDR inside a frame is treated as data; there is no resync.
- Execution timing: CS byte strobed at cycle t.
  - Checksum match: register writes visible at t+1. For commit/defaults, update=1 at t+1 for exactly one cycle. Shadow writes do not pulse update.
  - Checksum mismatch: no register change; cmd_err=1 at t+1.
- busy = (state != IDLE), registered.
- Timeout:
  - Counter clears on every rx_done and is held at 0 in IDLE.
  - Outside IDLE it increments each cycle.
  - Reaching TIMEOUT_CYC-1 forces IDLE with cmd_err pulse, discarding the partial frame; shadows are unchanged.
  - rx_done in the same cycle as expiry: the byte wins and the counter clears.
- Active outputs change only on commit, defaults or reset, never on a shadow write.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); the partial frame is lost.
- Back-to-back rx_done on consecutive cycles is supported.

Decomposition:
- Shared package dds_pkg holds:
  - HDR
  - opcode constants OP_PHASE, OP_FTW, OP_COMMIT, OP_DEFAULT
  - state enum
  - PH_W and FTW_W defaults
- One natural sub-module, dds_frame_rx: FSM, timeout counter and checksum. It emits a one-cycle frame_ok with cmd/data, or frame_err.
- The top-level block holds the shadow/active register banks and the update logic.

Test Plan:
- Write phase ch2 (AA 02 01 2C 2F), then commit (AA 80 00 00 80) -> phase_3=10'h12C one cycle after the commit CS, update pulse of one cycle, other phases still 0.
- Write ftw ch0 = 16'h4000 (AA 40 40 00 00) without commit -> ftw_1 stays 1024, update stays 0. After commit -> ftw_1=16'h4000.
- Bad checksum (AA 00 00 05 00) -> cmd_err pulse, all shadow/active unchanged, busy drops after CS.
- Send AA 01, then idle TIMEOUT_CYC cycles -> cmd_err pulse and busy=0. A following full valid frame executes normally.
- Garbage bytes 55 13, then a valid frame -> leading bytes ignored, frame executes. Next, assert rst mid-frame after AA 00 -> outputs return to 0/DEF_FTW immediately and FSM is in IDLE.
- Set all four phases, commit, then defaults (AA C0 00 00 C0) -> all phases 0, all ftw 1024, single update pulse.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants, opcode and state types for the DDS command controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_pkg;

    localparam logic [7:0]  HDR         = 8'hAA;
    localparam int          PH_W        = 10;
    localparam int          FTW_W       = 16;
    localparam logic [15:0] DEF_FTW     = 16'd1024;
    localparam int          TIMEOUT_CYC = 500000;

    // CMD[7:6] opcodes
    typedef enum logic [1:0] {
        OP_PHASE   = 2'b00,
        OP_FTW     = 2'b01,
        OP_COMMIT  = 2'b10,
        OP_DEFAULT = 2'b11
    } op_t;

    // Frame receiver position: which byte is expected next
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CS   = 3'd4
    } rx_state_t;

    // Frame checksum: XOR of the three payload bytes
    function automatic logic [7:0] frame_cs(input logic [7:0] cmd,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
        return cmd ^ dhi ^ dlo;
    endfunction

endpackage

// File: rtl/dds_cmd_ctrl_if.sv
// Byte input and DDS configuration output bundle of the command controller.
// Latency: n/a (wiring only).
// Backpressure: none; rx_done is a strobe that is always accepted.
interface dds_cmd_ctrl_if
    import dds_pkg::*;
#(
    parameter int PH_W  = dds_pkg::PH_W,
    parameter int FTW_W = dds_pkg::FTW_W
);
    logic [7:0]       rx_data;
    logic             rx_done;
    logic [PH_W-1:0]  phase_1;
    logic [PH_W-1:0]  phase_2;
    logic [PH_W-1:0]  phase_3;
    logic [PH_W-1:0]  phase_4;
    logic [FTW_W-1:0] ftw_1;
    logic [FTW_W-1:0] ftw_2;
    logic [FTW_W-1:0] ftw_3;
    logic [FTW_W-1:0] ftw_4;
    logic             update;
    logic             cmd_err;
    logic             busy;

    // Byte source / DDS consumer side
    modport master (
        output rx_data, rx_done,
        input  phase_1, phase_2, phase_3, phase_4,
        input  ftw_1, ftw_2, ftw_3, ftw_4,
        input  update, cmd_err, busy
    );

    // Controller side
    modport slave (
        input  rx_data, rx_done,
        output phase_1, phase_2, phase_3, phase_4,
        output ftw_1, ftw_2, ftw_3, ftw_4,
        output update, cmd_err, busy
    );
endinterface

// File: rtl/dds_frame_rx.sv
// Frame parser: HDR,CMD,DHI,DLO,CS byte FSM with inter-byte timeout and checksum.
// Latency: frame_ok/frame_err are combinational in the cycle the CS byte (or expiry) occurs.
// Backpressure: none; every rx_done byte is consumed, partial frames drop on timeout.
module dds_frame_rx
    import dds_pkg::*;
#(
    parameter logic [7:0] HDR         = dds_pkg::HDR,
    parameter int         TIMEOUT_CYC = dds_pkg::TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        frame_ok,
    output logic        frame_err,
    output op_t         frame_op,
    output logic [1:0]  frame_ch,
    output logic [15:0] frame_dat,
    output logic        busy
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      dhi_q, dhi_d;
    logic [7:0]      dlo_q, dlo_d;

    // State, timeout counter and captured payload bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            dhi_q   <= '0;
            dlo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            dhi_q   <= dhi_d;
            dlo_q   <= dlo_d;
        end
    end

    // Byte sequencing; a byte arriving on the expiry cycle takes priority over the timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        dhi_d     = dhi_q;
        dlo_d     = dlo_q;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        if (rx_done) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: if (rx_data == HDR) state_d = ST_CMD;
                ST_CMD: begin
                    cmd_d   = rx_data;
                    state_d = ST_DHI;
                end
                ST_DHI: begin
                    dhi_d   = rx_data;
                    state_d = ST_DLO;
                end
                ST_DLO: begin
                    dlo_d   = rx_data;
                    state_d = ST_CS;
                end
                ST_CS: begin
                    state_d = ST_IDLE;
                    if (rx_data == frame_cs(cmd_q, dhi_q, dlo_q)) frame_ok = 1'b1;
                    else                                          frame_err = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                frame_err = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign frame_op  = op_t'(cmd_q[7:6]);
    assign frame_ch  = cmd_q[1:0];
    assign frame_dat = {dhi_q, dlo_q};
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/dds_cmd_ctrl.sv
// Command controller: shadow/active phase and FTW banks fed by validated serial frames.
// Latency: register writes, update and cmd_err visible one cycle after the CS byte strobe.
// Backpressure: none; bytes are strobed in, malformed or stalled frames raise cmd_err.
module dds_cmd_ctrl
    import dds_pkg::*;
#(
    parameter logic [7:0]       HDR         = dds_pkg::HDR,
    parameter int               PH_W        = dds_pkg::PH_W,
    parameter int               FTW_W       = dds_pkg::FTW_W,
    parameter logic [FTW_W-1:0] DEF_FTW     = FTW_W'(dds_pkg::DEF_FTW),
    parameter int               TIMEOUT_CYC = dds_pkg::TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst,
    dds_cmd_ctrl_if.slave bus
);

    logic        frame_ok;
    logic        frame_err;
    op_t         frame_op;
    logic [1:0]  frame_ch;
    logic [15:0] frame_dat;
    logic        rx_busy;

    dds_frame_rx #(
        .HDR         (HDR),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (bus.rx_data),
        .rx_done   (bus.rx_done),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .frame_op  (frame_op),
        .frame_ch  (frame_ch),
        .frame_dat (frame_dat),
        .busy      (rx_busy)
    );

    logic [3:0][PH_W-1:0]  ph_sh_q,   ph_sh_d;
    logic [3:0][PH_W-1:0]  ph_act_q,  ph_act_d;
    logic [3:0][FTW_W-1:0] ftw_sh_q,  ftw_sh_d;
    logic [3:0][FTW_W-1:0] ftw_act_q, ftw_act_d;
    logic                  update_q,  update_d;
    logic                  cmd_err_q, cmd_err_d;

    // Shadow and active register banks plus one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_sh_q   <= '0;
            ph_act_q  <= '0;
            ftw_sh_q  <= {4{DEF_FTW}};
            ftw_act_q <= {4{DEF_FTW}};
            update_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            ph_sh_q   <= ph_sh_d;
            ph_act_q  <= ph_act_d;
            ftw_sh_q  <= ftw_sh_d;
            ftw_act_q <= ftw_act_d;
            update_q  <= update_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Execute a validated frame; active bank moves only as a whole so channels stay aligned
    always_comb begin
        ph_sh_d   = ph_sh_q;
        ph_act_d  = ph_act_q;
        ftw_sh_d  = ftw_sh_q;
        ftw_act_d = ftw_act_q;
        update_d  = 1'b0;
        cmd_err_d = frame_err;
        if (frame_ok) begin
            case (frame_op)
                OP_PHASE: ph_sh_d[frame_ch]  = PH_W'(frame_dat);
                OP_FTW:   ftw_sh_d[frame_ch] = FTW_W'(frame_dat);
                OP_COMMIT: begin
                    ph_act_d  = ph_sh_q;
                    ftw_act_d = ftw_sh_q;
                    update_d  = 1'b1;
                end
                OP_DEFAULT: begin
                    ph_sh_d   = '0;
                    ph_act_d  = '0;
                    ftw_sh_d  = {4{DEF_FTW}};
                    ftw_act_d = {4{DEF_FTW}};
                    update_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.phase_1 = ph_act_q[0];
    assign bus.phase_2 = ph_act_q[1];
    assign bus.phase_3 = ph_act_q[2];
    assign bus.phase_4 = ph_act_q[3];
    assign bus.ftw_1   = ftw_act_q[0];
    assign bus.ftw_2   = ftw_act_q[1];
    assign bus.ftw_3   = ftw_act_q[2];
    assign bus.ftw_4   = ftw_act_q[3];
    assign bus.update  = update_q;
    assign bus.cmd_err = cmd_err_q;
    assign bus.busy    = rx_busy;

endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// Bench for dds_cmd_ctrl: frame-level reference model checked every cycle, plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_dds_cmd_ctrl;
    import dds_pkg::*;

    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dds_cmd_ctrl_if #(.PH_W(10), .FTW_W(16)) dif ();

    dds_cmd_ctrl #(
        .HDR         (8'hAA),
        .PH_W        (10),
        .FTW_W       (16),
        .DEF_FTW     (16'd1024),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    logic [9:0]  m_ph_sh  [4];
    logic [9:0]  m_ph_act [4];
    logic [15:0] m_ftw_sh [4];
    logic [15:0] m_ftw_act[4];
    logic [7:0]  fb[5];
    int          fn;
    int          idle;
    bit          m_upd;
    bit          m_err;

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_ph_sh[i]   = '0;
            m_ph_act[i]  = '0;
            m_ftw_sh[i]  = 16'd1024;
            m_ftw_act[i] = 16'd1024;
        end
        fn    = 0;
        idle  = 0;
        m_upd = 0;
        m_err = 0;
    endfunction

    function automatic void m_exec();
        logic [15:0] w;
        int          ch;
        w  = {fb[2], fb[3]};
        ch = int'(fb[1][1:0]);
        if (fb[4] != (fb[1] ^ fb[2] ^ fb[3])) begin
            m_err = 1;
        end else begin
            case (fb[1][7:6])
                2'b00: m_ph_sh[ch]  = w[9:0];
                2'b01: m_ftw_sh[ch] = w;
                2'b10: begin
                    for (int i = 0; i < 4; i++) begin
                        m_ph_act[i]  = m_ph_sh[i];
                        m_ftw_act[i] = m_ftw_sh[i];
                    end
                    m_upd = 1;
                end
                default: begin
                    m_reset();
                    m_upd = 1;
                end
            endcase
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reset();
        end else begin
            m_upd = 0;
            m_err = 0;
            if (dif.rx_done) begin
                idle = 0;
                if (fn == 0) begin
                    if (dif.rx_data == 8'hAA) begin
                        fb[0] = dif.rx_data;
                        fn    = 1;
                    end
                end else begin
                    fb[fn] = dif.rx_data;
                    fn++;
                    if (fn == 5) begin
                        fn = 0;
                        m_exec();
                    end
                end
            end else if (fn > 0) begin
                idle++;
                if (idle == TO) begin
                    fn    = 0;
                    idle  = 0;
                    m_err = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("phase_1", dif.phase_1, m_ph_act[0]);
        check("phase_2", dif.phase_2, m_ph_act[1]);
        check("phase_3", dif.phase_3, m_ph_act[2]);
        check("phase_4", dif.phase_4, m_ph_act[3]);
        check("ftw_1",   dif.ftw_1,   m_ftw_act[0]);
        check("ftw_2",   dif.ftw_2,   m_ftw_act[1]);
        check("ftw_3",   dif.ftw_3,   m_ftw_act[2]);
        check("ftw_4",   dif.ftw_4,   m_ftw_act[3]);
        check("update",  dif.update,  m_upd);
        check("cmd_err", dif.cmd_err, m_err);
        check("busy",    dif.busy,    fn > 0);
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; bytes go out back-to-back, returns at the negedge after the last byte.
    task automatic send(input int n, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                        input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00,
                        input logic [7:0] b4 = 8'h00);
        logic [7:0] b[5];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
        for (int i = 0; i < n; i++) begin
            dif.rx_data = b[i];
            dif.rx_done = 1'b1;
            @(negedge clk);
        end
        dif.rx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int waited;
        rst         = 1'b1;
        dif.rx_data = 8'h00;
        dif.rx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst phase_1", dif.phase_1, 10'h000);
        check("rst ftw_4",   dif.ftw_4,   16'd1024);
        check("rst update",  dif.update,  1'b0);
        check("rst cmd_err", dif.cmd_err, 1'b0);
        check("rst busy",    dif.busy,    1'b0);

        // Phase ch2 write then commit
        send(5, 8'hAA, 8'h02, 8'h01, 8'h2C, 8'h2F);
        check("shadow only phase_3", dif.phase_3, 10'h000);
        check("shadow no update",    dif.update,  1'b0);
        send(5, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h80);
        check("commit phase_3",  dif.phase_3, 10'h12C);
        check("commit update",   dif.update,  1'b1);
        check("commit phase_1",  dif.phase_1, 10'h000);
        check("commit phase_4",  dif.phase_4, 10'h000);
        @(negedge clk);
        check("update one cycle", dif.update, 1'b0);

        // FTW ch0 write without commit, then commit
        send(5, 8'hAA, 8'h40, 8'h40, 8'h00, 8'h00);
        check("ftw_1 before commit", dif.ftw_1,  16'd1024);
        check("ftw write no update", dif.update, 1'b0);
        send(5, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h80);
        check("ftw_1 after commit", dif.ftw_1, 16'h4000);

        // Bad checksum
        send(5, 8'hAA, 8'h00, 8'h00, 8'h05, 8'h00);
        check("bad cs cmd_err", dif.cmd_err, 1'b1);
        check("bad cs busy",    dif.busy,    1'b0);
        check("bad cs phase_3", dif.phase_3, 10'h12C);
        send(5, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h80);
        check("bad cs shadow kept", dif.phase_1, 10'h000);

        // Timeout after HDR, CMD
        send(2, 8'hAA, 8'h01);
        check("partial busy", dif.busy, 1'b1);
        waited = 0;
        while (dif.cmd_err !== 1'b1 && waited < TO + 10) begin
            @(negedge clk);
            waited++;
        end
        check("timeout cmd_err",  dif.cmd_err, 1'b1);
        check("timeout latency",  waited,      TO);
        check("timeout busy",     dif.busy,    1'b0);
        send(5, 8'hAA, 8'h01, 8'h00, 8'h07, 8'h06);
        send(5, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h80);
        check("post timeout phase_2", dif.phase_2, 10'h007);

        // Leading garbage, phase truncation on ch3
        send(2, 8'h55, 8'h13);
        check("garbage busy", dif.busy, 1'b0);
        send(5, 8'hAA, 8'h03, 8'hFF, 8'hFF, 8'h03);
        send(5, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h80);
        check("trunc phase_4", dif.phase_4, 10'h3FF);

        // Reset mid-frame
        send(2, 8'hAA, 8'h00);
        #1 rst = 1'b1;
        #1;
        check("mid rst phase_4", dif.phase_4, 10'h000);
        check("mid rst ftw_1",   dif.ftw_1,   16'd1024);
        check("mid rst busy",    dif.busy,    1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(5, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h80);
        check("mid rst frame lost", dif.phase_1, 10'h000);

        // All four phases, commit, then defaults
        send(5, 8'hAA, 8'h00, 8'h00, 8'h01, 8'h01);
        send(5, 8'hAA, 8'h01, 8'h00, 8'h02, 8'h03);
        send(5, 8'hAA, 8'h02, 8'h00, 8'h03, 8'h01);
        send(5, 8'hAA, 8'h03, 8'h00, 8'h04, 8'h07);
        send(5, 8'hAA, 8'h43, 8'h12, 8'h34, 8'h65);
        send(5, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h80);
        check("all phase_1", dif.phase_1, 10'h001);
        check("all phase_4", dif.phase_4, 10'h004);
        check("all ftw_4",   dif.ftw_4,   16'h1234);
        send(5, 8'hAA, 8'hC0, 8'h00, 8'h00, 8'hC0);
        check("dflt phase_2", dif.phase_2, 10'h000);
        check("dflt ftw_4",   dif.ftw_4,   16'd1024);
        check("dflt update",  dif.update,  1'b1);
        @(negedge clk);
        check("dflt single pulse", dif.update, 1'b0);
        send(5, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h80);
        check("dflt shadow ftw_4", dif.ftw_4, 16'd1024);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
